// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the asynchronous instruction
// memory, and buffers {pc, inst} pairs in a small registered queue that
// decode drains over a valid/ready handshake. Redirect flushes the queue
// and restarts fetch at the (word-aligned) target.
// Optional: define FETCH_PERF_CNT_EN to add fetch/stall/flush counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      entry_pc_q   [FQ_DEPTH];
  logic [31:0]      entry_pc_d   [FQ_DEPTH];
  logic [31:0]      entry_inst_q [FQ_DEPTH];
  logic [31:0]      entry_inst_d [FQ_DEPTH];

  logic deq;
  logic enq;

  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != '0);
  assign id_pc       = entry_pc_q[rd_ptr_q];
  assign id_inst     = entry_inst_q[rd_ptr_q];
  assign id_pc_plus4 = id_pc + 32'd4;

  // Handshake qualifiers; a full queue may still accept when the head leaves.
  always_comb begin
    deq = id_valid & id_ready;
    enq = fetch_en & ~redirect_valid & ((count_q < FULL_CNT) | deq);
  end

  // Next-state for PC, pointers, occupancy and queue storage.
  always_comb begin
    pc_d         = pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    entry_pc_d   = entry_pc_q;
    entry_inst_d = entry_inst_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        entry_pc_d[wr_ptr_q]   = pc_q;
        entry_inst_d[wr_ptr_q] = imem_dout;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        pc_d                   = pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; synchronous active-low reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC_ALIGNED;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        entry_pc_q[i]   <= '0;
        entry_inst_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      entry_pc_q   <= entry_pc_d;
      entry_inst_q <= entry_inst_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;

  // Stall means fetch wanted to proceed but the queue was full and not draining.
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + {31'd0, enq};
    perf_stall_cnt_d = perf_stall_cnt_q
                     + {31'd0, fetch_en & ~redirect_valid & (count_q == FULL_CNT) & ~deq};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, redirect_valid};
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end
`endif

endmodule
